hilo_mult_unit: RTL and testbench
=================================

Name: hilo_mult_unit

Overview:
- Multicycle sequencer and HI/LO register pair that sits directly downstream of the unsigned 32x32 array multiplier.
- Registers the operands that drive the multiplier and waits a fixed multicycle-path latency for its result.
- Applies the signed-MULT correction when required, then commits the result to the architectural HI/LO registers.
- Serves MFHI/MFLO/MTHI/MTLO for the datapath and stalls reads while a multiply is in flight.

Parameters:
- LATENCY, 4, cycles allowed for the combinational multiplier to settle; legal range 1..15.
- CNT_W, 4, width of the latency counter; must hold LATENCY.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- mul_start  in  1  one-cycle request to start MULT/MULTU; sampled only in IDLE.
- mul_signed  in  1  1 = MULT (signed), 0 = MULTU; sampled with mul_start.
- op_a  in  32  multiplicand (rs).
- op_b  in  32  multiplier (rt).
- mcnd  out  32  registered operand A, drives the multiplier's A input.
- mplr  out  32  registered operand B, drives the multiplier's B input.
- prod_hi  in  32  multiplier HI output (unsigned product bits 63:32).
- prod_lo  in  32  multiplier LO output (unsigned product bits 31:0).
- wr_hi  in  1  MTHI strobe.
- wr_lo  in  1  MTLO strobe.
- wr_data  in  32  MTHI/MTLO data.
- rd_en  in  1  MFHI/MFLO request.
- rd_sel  in  1  0 = HI, 1 = LO.
- rd_data  out  32  selected register, combinational from HI/LO.
- stall  out  1  rd_en & busy; the datapath must hold the instruction.
- busy  out  1  multiply in flight.
- done  out  1  one-cycle pulse when HI/LO have been committed.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset (RST low, asynchronous):
  - state = IDLE.
  - hi, lo, mcnd, mplr = 0.
  - counter = 0.
  - busy, done, stall = 0.
  - Reset mid-multiply aborts the multiply; no partial commit.
- State IDLE:
  - mul_start=1 at edge N latches mcnd<=op_a, mplr<=op_b, sign flag<=mul_signed, counter<=LATENCY.
  - State becomes BUSY; busy=1 from cycle N+1.
- State BUSY:
  - Counter decrements each edge.
  - On the edge where counter==1, commit HI/LO; state becomes IDLE; busy falls and done=1 for exactly one cycle.
  - Commit therefore occurs at edge N+LATENCY; done is high during cycle N+LATENCY.
- mul_start in BUSY is ignored; the issuer must honour busy.
- mul_start in the done cycle is legal and starts a new multiply, because the state is IDLE.
- Commit arithmetic:
  - lo <= prod_lo.
  - Unsigned: hi <= prod_hi.
  - Signed: hi <= prod_hi - (mcnd[31] ? mplr : 0) - (mplr[31] ? mcnd : 0), modulo 2^32.
- MTHI/MTLO:
  - Write on the next edge in any state.
  - If a write lands on the commit edge, the commit wins for both registers.
  - A write during BUSY is overwritten by the later commit.
  - wr_hi and wr_lo asserted together write both registers.
- Reads:
  - rd_data = rd_sel ? lo : hi.
  - stall = rd_en & busy.
  - In the done cycle stall=0 and rd_data already shows the new value.
- mcnd/mplr hold their values until the next accepted start.

Optional Feature:
- Macro: HILO_EARLY_FWD_EN.
- Defined:
  - stall is also 0 in the final BUSY cycle (counter==1).
  - rd_data then returns the corrected product being committed that cycle, saving one stall cycle.
- Undefined: stall covers all BUSY cycles, as specified above.

Decomposition:
- Shared package holds:
  - State encodings HILO_IDLE=1'b0 and HILO_BUSY=1'b1.
  - RD_SEL_HI=0 and RD_SEL_LO=1.
  - The default latency constant.
- One natural sub-module: hilo_sign_fix. It is the combinational signed-correction subtractor, built from two 32-bit add/sub instances in subtract mode.
- The multiplier itself stays outside this block.

Test Plan:
- Reset mid-BUSY: start, drop RST two cycles later -> hi=lo=0, busy=0, done never pulses; a later start behaves normally.
- MULTU: op_a=0xFFFFFFFF, op_b=0x00000002, LATENCY=4 -> busy 4 cycles, done at cycle 4, hi=0x00000001, lo=0xFFFFFFFE.
- MULT signed:
  - op_a=0xFFFFFFFE (-2), op_b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - op_a=op_b=0xFFFFFFFF -> hi=0x00000000, lo=0x00000001.
- Read stall: rd_en=1, rd_sel=1 throughout a multiply:
  - Without the macro, stall high for all busy cycles, then rd_data=new lo in the done cycle.
  - With HILO_EARLY_FWD_EN, stall drops one cycle earlier with the correct data.
- Write/commit collision: MTHI 0x12345678 in the middle of BUSY, then MTLO on the commit edge -> hi and lo both hold product values; a later MTHI in IDLE sets hi=0x12345678 next cycle.
- Back-to-back: second mul_start in the done cycle, with mul_start also held during BUSY -> the second multiply is accepted exactly once and the extra starts are ignored.

Source files
------------

// File: rtl/hilo_mult_unit_pkg.sv
// rtl/hilo_mult_unit_pkg.sv - shared encodings and defaults for the HI/LO multiply unit
package hilo_mult_unit_pkg;

    typedef enum logic {
        HILO_IDLE = 1'b0,
        HILO_BUSY = 1'b1
    } hilo_state_e;

    localparam logic RD_SEL_HI = 1'b0;
    localparam logic RD_SEL_LO = 1'b1;

    localparam int HILO_DEFAULT_LATENCY = 4;

endpackage

// File: rtl/hilo_mult_unit_addsub.sv
// rtl/hilo_mult_unit_addsub.sv - 32-bit adder/subtractor, y = a + b or a - b modulo 2^32
module hilo_addsub (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        sub_i,
    output logic [31:0] y_o
);

    // Two's-complement subtract: invert b and inject the carry-in
    assign y_o = a_i + (b_i ^ {32{sub_i}}) + {31'd0, sub_i};

endmodule

// File: rtl/hilo_mult_unit_sign_fix.sv
// rtl/hilo_mult_unit_sign_fix.sv - turns the unsigned product high word into the signed high word
module hilo_sign_fix (
    input  logic [31:0] prod_hi_i,
    input  logic [31:0] mcnd_i,
    input  logic [31:0] mplr_i,
    input  logic        signed_i,
    output logic [31:0] hi_fix_o
);

    logic [31:0] corr_a;
    logic [31:0] corr_b;
    logic [31:0] partial;

    // A negative operand contributes 2^32 * (other operand) too much to the unsigned product
    assign corr_a = (signed_i && mcnd_i[31]) ? mplr_i : 32'd0;
    assign corr_b = (signed_i && mplr_i[31]) ? mcnd_i : 32'd0;

    hilo_addsub u_sub_a (
        .a_i   (prod_hi_i),
        .b_i   (corr_a),
        .sub_i (1'b1),
        .y_o   (partial)
    );

    hilo_addsub u_sub_b (
        .a_i   (partial),
        .b_i   (corr_b),
        .sub_i (1'b1),
        .y_o   (hi_fix_o)
    );

endmodule

// File: rtl/hilo_mult_unit.sv
// rtl/hilo_mult_unit.sv - multicycle multiply sequencer with HI/LO registers; option HILO_EARLY_FWD_EN
module hilo_mult_unit
    import hilo_mult_unit_pkg::*;
#(
    parameter int LATENCY = HILO_DEFAULT_LATENCY,
    parameter int CNT_W   = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        mul_start,
    input  logic        mul_signed,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic [31:0] mcnd,
    output logic [31:0] mplr,
    input  logic [31:0] prod_hi,
    input  logic [31:0] prod_lo,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] wr_data,
    input  logic        rd_en,
    input  logic        rd_sel,
    output logic [31:0] rd_data,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    hilo_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      mcnd_q;
    logic [31:0]      mplr_q;
    logic             sgn_q;
    logic             done_q;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic [31:0]      hi_d;
    logic [31:0]      lo_d;
    logic [31:0]      hi_fix;
    logic             last_cycle;

    assign last_cycle = (state_q == HILO_BUSY) && (cnt_q == CNT_W'(1));

    hilo_sign_fix u_sign_fix (
        .prod_hi_i (prod_hi),
        .mcnd_i    (mcnd_q),
        .mplr_i    (mplr_q),
        .signed_i  (sgn_q),
        .hi_fix_o  (hi_fix)
    );

    // The commit overrides any MTHI/MTLO landing on the same edge
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (last_cycle) begin
            hi_d = hi_fix;
            lo_d = prod_lo;
        end else begin
            if (wr_hi) hi_d = wr_data;
            if (wr_lo) lo_d = wr_data;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= HILO_IDLE;
            cnt_q   <= '0;
            mcnd_q  <= '0;
            mplr_q  <= '0;
            sgn_q   <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            done_q <= 1'b0;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            case (state_q)
                HILO_IDLE: begin
                    if (mul_start) begin
                        mcnd_q  <= op_a;
                        mplr_q  <= op_b;
                        sgn_q   <= mul_signed;
                        cnt_q   <= CNT_W'(LATENCY);
                        state_q <= HILO_BUSY;
                    end
                end
                HILO_BUSY: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (last_cycle) begin
                        state_q <= HILO_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= HILO_IDLE;
            endcase
        end
    end

    assign mcnd = mcnd_q;
    assign mplr = mplr_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = (state_q == HILO_BUSY);
    assign done = done_q;

`ifdef HILO_EARLY_FWD_EN
    // Final busy cycle: hand the product being committed straight to the reader
    assign stall   = rd_en & busy & ~last_cycle;
    assign rd_data = last_cycle ? ((rd_sel == RD_SEL_LO) ? prod_lo : hi_fix)
                                : ((rd_sel == RD_SEL_LO) ? lo_q : hi_q);
`else
    assign stall   = rd_en & busy;
    assign rd_data = (rd_sel == RD_SEL_LO) ? lo_q : hi_q;
`endif

endmodule

// File: tb/tb_hilo_mult_unit.sv
// tb/tb_hilo_mult_unit.sv - scoreboard bench for hilo_mult_unit
module tb_hilo_mult_unit;

    localparam int LAT = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic        mul_start;
    logic        mul_signed;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] mcnd;
    logic [31:0] mplr;
    logic [31:0] prod_hi;
    logic [31:0] prod_lo;
    logic        wr_hi;
    logic        wr_lo;
    logic [31:0] wr_data;
    logic        rd_en;
    logic        rd_sel;
    logic [31:0] rd_data;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    hilo_mult_unit #(.LATENCY(LAT), .CNT_W(4)) dut (
        .CLK(CLK), .RST(RST), .mul_start(mul_start), .mul_signed(mul_signed),
        .op_a(op_a), .op_b(op_b), .mcnd(mcnd), .mplr(mplr),
        .prod_hi(prod_hi), .prod_lo(prod_lo), .wr_hi(wr_hi), .wr_lo(wr_lo),
        .wr_data(wr_data), .rd_en(rd_en), .rd_sel(rd_sel), .rd_data(rd_data),
        .stall(stall), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 CLK = ~CLK;

    // External unsigned array multiplier
    always_comb begin
        logic [63:0] p;
        p = {32'd0, mcnd} * {32'd0, mplr};
        prod_hi = p[63:32];
        prod_lo = p[31:0];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Monitor: every done pulse must match the oldest outstanding multiply
    always @(negedge CLK) begin
        if (RST === 1'b1 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending multiply");
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("commit_hi", hi, e[63:32]);
                chk("commit_lo", lo, e[31:0]);
            end
        end
    end

    task automatic start_mul(input logic [31:0] a, input logic [31:0] b, input logic s,
                             input logic [31:0] eh, input logic [31:0] el);
        exp_q.push_back({eh, el});
        op_a       = a;
        op_b       = b;
        mul_signed = s;
        mul_start  = 1'b1;
        tick();
        mul_start  = 1'b0;
    endtask

    // mode 0: plain, 1: read held throughout, 2: MTHI mid-busy and MTLO on the commit edge
    task automatic wait_commit(input string nm, input int mode, input logic [31:0] elo);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            n++;
            if (mode == 1) begin
`ifdef HILO_EARLY_FWD_EN
                chk({nm, "_stall"}, {31'd0, stall}, (n < LAT) ? 32'd1 : 32'd0);
                if (n == LAT) chk({nm, "_fwd_data"}, rd_data, elo);
`else
                chk({nm, "_stall"}, {31'd0, stall}, 32'd1);
`endif
            end
            if (mode == 2) begin
                wr_hi   = (n == 2);
                wr_lo   = (n == LAT);
                wr_data = (n == 2) ? 32'h12345678 : 32'h00000055;
            end
            tick();
        end
        wr_hi = 1'b0;
        wr_lo = 1'b0;
        chk({nm, "_busy_cycles"}, n, LAT);
        chk({nm, "_done"}, {31'd0, done}, 32'd1);
        if (mode == 1) begin
            chk({nm, "_done_stall"}, {31'd0, stall}, 32'd0);
            chk({nm, "_done_rd_data"}, rd_data, elo);
        end
    endtask

    initial begin
        RST = 1'b0; mul_start = 0; mul_signed = 0; op_a = 0; op_b = 0;
        wr_hi = 0; wr_lo = 0; wr_data = 0; rd_en = 0; rd_sel = 0;
        tick();
        tick();
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_mcnd", mcnd, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        RST = 1'b1;
        tick();

        wr_hi = 1; wr_lo = 1; wr_data = 32'hA5A5A5A5;
        tick();
        wr_hi = 0; wr_lo = 0;
        chk("mt_both_hi", hi, 32'hA5A5A5A5);
        chk("mt_both_lo", lo, 32'hA5A5A5A5);

        // Abort mid-multiply: nothing pushed, so any done is flagged by the monitor
        op_a = 32'd3; op_b = 32'd5; mul_start = 1;
        tick();
        mul_start = 0;
        tick();
        tick();
        RST = 1'b0;
        #1;
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_mplr", mplr, 32'd0);
        tick();
        RST = 1'b1;
        repeat (6) tick();

        start_mul(32'hFFFFFFFF, 32'h00000002, 1'b0, 32'h00000001, 32'hFFFFFFFE);
        wait_commit("multu", 0, 32'hFFFFFFFE);
        tick();
        start_mul(32'hFFFFFFFE, 32'h00000003, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFA);
        wait_commit("mult_neg2x3", 0, 32'hFFFFFFFA);
        tick();
        start_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h00000001);
        wait_commit("mult_m1xm1", 0, 32'h00000001);
        tick();
        start_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001);
        wait_commit("multu_maxsq", 0, 32'h00000001);
        tick();

        rd_en = 1; rd_sel = 1;
        start_mul(32'h80000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 32'h80000000);
        wait_commit("rd_lo", 1, 32'h80000000);
        rd_sel = 0;
        #1;
        chk("rd_hi_after", rd_data, 32'hFFFFFFFF);
        tick();
        rd_en = 0;

        start_mul(32'h00010000, 32'h00010000, 1'b0, 32'h00000001, 32'h00000000);
        wait_commit("collide", 2, 32'h00000000);
        tick();
        wr_hi = 1; wr_data = 32'h12345678;
        tick();
        wr_hi = 0;
        chk("mthi_idle", hi, 32'h12345678);
        chk("mthi_idle_lo_kept", lo, 32'h00000000);

        // Back-to-back: start held high through busy and into the done cycle
        start_mul(32'h12345678, 32'h00000010, 1'b0, 32'h00000001, 32'h23456780);
        op_a = 32'hFFFFFFFF; op_b = 32'h00000005; mul_signed = 1; mul_start = 1;
        exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFFB});
        wait_commit("b2b_first", 0, 32'h23456780);
        chk("b2b_mcnd_held", mcnd, 32'h12345678);
        tick();
        mul_start = 0;
        chk("b2b_mcnd_new", mcnd, 32'hFFFFFFFF);
        wait_commit("b2b_second", 0, 32'hFFFFFFFB);
        repeat (8) tick();
        chk("b2b_no_restart", {31'd0, busy}, 32'd0);
        chk("pending_left", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
